// File: rtl/pe_operand_loader.sv
// pe_operand_loader: assembles a byte-serial operand frame (bias, count K,
// K weight bytes, K input bytes) into wide registered vectors for the PE.
// The frame is held stable behind a valid/ready handshake until it is consumed.
// Optional build macro LOADER_REUSE_WEIGHTS_EN: count-byte bit 7 keeps the
// previous weight vector and the frame carries only the K input bytes.
module pe_operand_loader #(
  parameter int N_LANES = 62,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           bias,
  output logic [N_LANES*DATA_W-1:0]   weight,
  output logic [N_LANES*DATA_W-1:0]   in,
  output logic                        err,
  output logic [1:0]                  err_code
);

  typedef enum logic [2:0] {
    S_BIAS,
    S_COUNT,
    S_WEIGHT,
    S_INPUT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [1:0] EC_COUNT   = 2'd1;
  localparam logic [1:0] EC_EARLY   = 2'd2;
  localparam logic [1:0] EC_MISSING = 2'd3;
  localparam logic [6:0] N_LANES_K  = 7'(N_LANES);

  state_t     state;
  logic [6:0] k;
  logic [6:0] idx;
  logic       xfer;
  logic [6:0] k_in;
  logic       range_ok;
  logic       count_ok;
  logic       reuse;
  logic       last_lane;

  // The loader only refuses bytes while a frame waits for the PE, or in reset.
  assign s_ready   = ~rst & (state != S_HOLD);
  assign xfer      = s_valid & s_ready;
  assign k_in      = s_data[6:0];
  assign range_ok  = (k_in != 7'd0) && (k_in <= N_LANES_K);
  assign last_lane = (idx == k - 7'd1);

`ifdef LOADER_REUSE_WEIGHTS_EN
  assign reuse    = s_data[7];
  assign count_ok = range_ok;
`else
  assign reuse    = 1'b0;
  assign count_ok = range_ok & ~s_data[7];
`endif

  // Frame-assembly FSM: walks the byte stream, fills lanes, flags framing errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BIAS;
      k        <= 7'd0;
      idx      <= 7'd0;
      bias     <= '0;
      weight   <= '0;
      in       <= '0;
      m_valid  <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      err <= 1'b0;
      case (state)
        S_BIAS: begin
          if (xfer) begin
            bias <= s_data;
            if (s_last) begin
              err      <= 1'b1;
              err_code <= EC_EARLY;
            end else begin
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (xfer) begin
            if (!count_ok) begin
              err      <= 1'b1;
              err_code <= EC_COUNT;
              state    <= s_last ? S_BIAS : S_DRAIN;
            end else if (s_last) begin
              err      <= 1'b1;
              err_code <= EC_EARLY;
              state    <= S_BIAS;
            end else begin
              k   <= k_in;
              idx <= 7'd0;
              // Unused upper lanes must read as zero for short frames.
              in  <= '0;
              if (reuse) begin
                state <= S_INPUT;
              end else begin
                weight <= '0;
                state  <= S_WEIGHT;
              end
            end
          end
        end
        S_WEIGHT: begin
          if (xfer) begin
            weight[int'(idx)*DATA_W +: DATA_W] <= s_data;
            if (s_last) begin
              err      <= 1'b1;
              err_code <= EC_EARLY;
              state    <= S_BIAS;
            end else if (last_lane) begin
              idx   <= 7'd0;
              state <= S_INPUT;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        S_INPUT: begin
          if (xfer) begin
            in[int'(idx)*DATA_W +: DATA_W] <= s_data;
            if (last_lane) begin
              if (s_last) begin
                m_valid <= 1'b1;
                state   <= S_HOLD;
              end else begin
                err      <= 1'b1;
                err_code <= EC_MISSING;
                state    <= S_DRAIN;
              end
            end else if (s_last) begin
              err      <= 1'b1;
              err_code <= EC_EARLY;
              state    <= S_BIAS;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        S_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_BIAS;
          end
        end
        S_DRAIN: begin
          // Silently discard the rest of a rejected frame.
          if (xfer && s_last) begin
            state <= S_BIAS;
          end
        end
        default: begin
          state <= S_BIAS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_loader.sv
// Scoreboard bench for pe_operand_loader: expected frames and error codes are
// queued as stimulus is driven and compared when the loader presents them.
module tb_pe_operand_loader;

  localparam int N = 62;
  localparam int W = N * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   bias;
  logic [W-1:0] weight;
  logic [W-1:0] in_v;
  logic         err;
  logic [1:0]   err_code;

  typedef struct packed {
    logic [7:0]   b;
    logic [W-1:0] w;
    logic [W-1:0] i;
  } frame_t;

  frame_t       exp_q[$];
  logic [1:0]   err_q[$];
  logic [7:0]   w_arr[N];
  logic [7:0]   i_arr[N];
  logic [W-1:0] model_w;
  logic [W-1:0] snap_w;
  logic [W-1:0] snap_i;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           seen = 1'b0;

  pe_operand_loader #(.N_LANES(N), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .bias     (bias),
    .weight   (weight),
    .in       (in_v),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader accepts it.
  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("sready_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drive a well-formed frame from w_arr/i_arr and queue its expected image.
  task automatic send_good(input logic [7:0] b, input int k);
    frame_t f;
    f.b = b;
    f.w = '0;
    f.i = '0;
    for (int l = 0; l < k; l++) begin
      f.w[l*8 +: 8] = w_arr[l];
      f.i[l*8 +: 8] = i_arr[l];
    end
    model_w = f.w;
    exp_q.push_back(f);
    send(b, 1'b0);
    send(8'(k), 1'b0);
    for (int l = 0; l < k; l++) send(w_arr[l], 1'b0);
    for (int l = 0; l < k; l++) send(i_arr[l], l == k - 1);
    check("mvalid_latency", m_valid, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("mvalid_drop", m_valid, 0);
    check("sready_after", s_ready, 1);
  endtask

  // Scoreboard side: compare error pulses and newly presented frames.
  always @(negedge clk) begin
    frame_t f;
    if (err) begin
      if (err_q.size() == 0) check("unexpected_err", err, 0);
      else check("err_code", err_code, err_q.pop_front());
    end
    if (m_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) check("unexpected_frame", m_valid, 0);
      else begin
        f = exp_q.pop_front();
        check("bias", bias, f.b);
        check("weight", weight, f.w);
        check("in", in_v, f.i);
      end
    end else if (!m_valid) begin
      seen = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_bias", bias, 0);
    check("rst_weight", weight, 0);
    rst = 1'b0;
    #1;
    check("idle_sready", s_ready, 1);

    // Reference frame from the test plan
    w_arr[0] = 8'h85; w_arr[1] = 8'h04; w_arr[2] = 8'h83; w_arr[3] = 8'h02;
    i_arr[0] = 8'h64; i_arr[1] = 8'h5D; i_arr[2] = 8'hE7; i_arr[3] = 8'hFF;
    send_good(8'h64, 4);
    check("plan_weight", weight[31:0], 32'h0283_0485);
    check("plan_in", in_v[31:0], 32'hFFE7_5D64);

    // Back-pressure: bytes offered while the frame waits must be refused
    snap_w = weight;
    snap_i = in_v;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("hold_sready", s_ready, 0);
      check("hold_mvalid", m_valid, 1);
      check("hold_weight", weight, snap_w);
      check("hold_in", in_v, snap_i);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("release_mvalid", m_valid, 0);
    check("release_sready", s_ready, 1);

    // Bad count, drained, then a good frame
    err_q.push_back(2'd1);
    send(8'h11, 1'b0); send(8'h00, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    check("badcnt_mvalid", m_valid, 0);
    check("badcnt_code", err_code, 1);
    w_arr[0] = 8'h11; w_arr[1] = 8'h92; w_arr[2] = 8'h33;
    i_arr[0] = 8'hC4; i_arr[1] = 8'h05; i_arr[2] = 8'h76;
    send_good(8'h9A, 3);
    consume();

    // Early last inside the weights, then a frame missing its last flag
    err_q.push_back(2'd2);
    send(8'h21, 1'b0); send(8'h04, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    check("early_code", err_code, 2);
    check("early_mvalid", m_valid, 0);
    err_q.push_back(2'd3);
    send(8'h22, 1'b0); send(8'h01, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0);
    send(8'h30, 1'b0); send(8'h40, 1'b1);
    check("missing_code", err_code, 3);
    check("missing_mvalid", m_valid, 0);
    w_arr[0] = 8'h5A; w_arr[1] = 8'hA5;
    i_arr[0] = 8'h0F; i_arr[1] = 8'hF0;
    send_good(8'h80, 2);
    consume();

    // Full width, then a single-lane frame that must zero the upper lanes
    for (int l = 0; l < N; l++) begin
      w_arr[l] = 8'h7F;
      i_arr[l] = 8'h7F;
    end
    send_good(8'h7F, N);
    consume();
    w_arr[0] = 8'h12; i_arr[0] = 8'h34;
    send_good(8'h01, 1);
    check("k1_upper_w", weight[W-1:8], 0);
    consume();

`ifdef LOADER_REUSE_WEIGHTS_EN
    begin
      frame_t f;
      w_arr[0] = 8'h01; w_arr[1] = 8'h82; w_arr[2] = 8'h03; w_arr[3] = 8'h84;
      i_arr[0] = 8'h10; i_arr[1] = 8'h20; i_arr[2] = 8'h30; i_arr[3] = 8'h40;
      send_good(8'h55, 4);
      consume();
      i_arr[0] = 8'hE1; i_arr[1] = 8'hE2; i_arr[2] = 8'hE3; i_arr[3] = 8'hE4;
      f.b = 8'h66;
      f.w = model_w;
      f.i = '0;
      for (int l = 0; l < 4; l++) f.i[l*8 +: 8] = i_arr[l];
      exp_q.push_back(f);
      send(8'h66, 1'b0); send(8'h84, 1'b0);
      for (int l = 0; l < 4; l++) send(i_arr[l], l == 3);
      check("reuse_mvalid", m_valid, 1);
      consume();
    end
`endif

    // Reset in the middle of the input bytes
    w_arr[0] = 8'hAB; w_arr[1] = 8'hCD;
    send_good(8'h42, 2);
    consume();
    send(8'h77, 1'b0); send(8'h02, 1'b0);
    send(8'h09, 1'b0); send(8'h0A, 1'b0); send(8'h0B, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_bias", bias, 0);
    check("mid_rst_weight", weight, 0);
    check("mid_rst_in", in_v, 0);
    check("mid_rst_mvalid", m_valid, 0);
    check("mid_rst_err_code", err_code, 0);
    check("mid_rst_sready", s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    w_arr[0] = 8'h3C; i_arr[0] = 8'hC3;
    send_good(8'h3C, 1);
    consume();

    repeat (3) @(posedge clk);
    check("frames_left", exp_q.size(), 0);
    check("errors_left", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_operand_loader.md
Name: pe_operand_loader

Overview:
- Upstream stage of the PE; feeds its bias, weight-vector and input-vector operands.
- Accepts a byte-serial operand stream over a valid/ready handshake and assembles one frame into wide registered vectors.
- Presents the frame to the PE with an output valid/ready handshake and holds it stable until the frame is consumed.
- All bytes are 8-bit sign-magnitude (bit 7 = sign, bits 6:0 = magnitude), passed through unmodified.

Parameters:
- N_LANES, 62, number of lanes in the weight and input vectors (1..127).
- DATA_W, 8, byte width; fixed at 8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- s_valid  input  1  stream byte valid.
- s_ready  output  1  loader can accept a byte.
- s_data  input  8  stream byte.
- s_last  input  1  final byte of the frame.
- m_valid  output  1  assembled frame available.
- m_ready  input  1  PE side consumes the frame.
- bias  output  8  bias operand.
- weight  output  N_LANES*8  weight vector; lane i occupies bits [8i+7:8i].
- in  output  N_LANES*8  input vector; same lane packing as weight.
- err  output  1  one-cycle pulse on a frame error.
- err_code  output  2  cause of the last error; held until the next error. Encoding: 1 = bad count, 2 = early last, 3 = missing last.

Behaviour:
- Reset: async active-high; one clock, with polarity and synchronicity fixed.
  - State goes to S_BIAS.
  - bias, weight, in, m_valid, err and err_code all reset to 0.
  - s_ready is 0 while rst is high.
- A byte transfers when s_valid and s_ready are both high at a clock edge.
- Frame format, in order:
  - bias byte.
  - count byte K (bits 6:0, valid range 1..N_LANES; bit 7 is reserved).
  - K weight bytes.
  - K input bytes.
  - Total frame length is 2K+2 bytes. The first weight and input bytes go to lane 0, ascending.
- FSM states: S_BIAS, S_COUNT, S_WEIGHT, S_INPUT, S_HOLD, S_DRAIN. s_ready = 1 in every state except S_HOLD.
- S_BIAS:
  - Captures bias, then moves to S_COUNT.
  - If s_last is set on this byte: early-last error, stay in S_BIAS.
- S_COUNT:
  - If K is valid: clear weight and in to all zeros, reset the lane index, and go to S_WEIGHT. Lanes K..N_LANES-1 therefore stay 0.
  - If K = 0, K > N_LANES, or bit 7 = 1: bad-count error, go to S_DRAIN. If s_last was on this byte, go to S_BIAS instead.
- S_WEIGHT:
  - Writes the byte into weight lane idx and increments idx.
  - After lane K-1 is written, idx resets and the state moves to S_INPUT.
- S_INPUT:
  - Writes in lane idx.
  - On lane K-1 with s_last = 1: go to S_HOLD; m_valid is 1 from the next cycle.
  - On lane K-1 with s_last = 0: missing-last error, go to S_DRAIN.
- Any byte before the final one with s_last = 1: early-last error, go to S_BIAS.
- S_DRAIN: discards bytes until a byte with s_last transfers, then goes to S_BIAS. No additional error is raised in this state.
- S_HOLD:
  - m_valid = 1 and operands are stable.
  - On m_valid & m_ready, go to S_BIAS; m_valid = 0 and s_ready = 1 on the next cycle.
  - A new frame therefore starts no earlier than one cycle after the handshake.
- On any error the frame is discarded and m_valid is never raised for it. The partially written operand registers are don't-care while m_valid = 0.
- Outputs change only while m_valid = 0.
- Reset asserted mid-frame or in S_HOLD aborts the frame immediately.
- Throughput: one byte per cycle while loading.

Optional Feature:
- Macro LOADER_REUSE_WEIGHTS_EN.
- When defined:
  - Count-byte bit 7 = 1 means "reuse weights". S_COUNT clears only in, keeps weight unchanged, skips S_WEIGHT and goes straight to S_INPUT.
  - The frame length becomes K+2 bytes.
  - K on bits 6:0 is still range-checked.
- When not defined: bit 7 = 1 is a bad-count error.

Test Plan:
- Frame: bias 0x64, K=4, weights 0x85,0x04,0x83,0x02, inputs 0x64,0x5D,0xE7,0xFF with s_last on the final byte.
  - Required: m_valid rises one cycle after the last transfer.
  - bias = 0x64.
  - weight = {464'b0, 0x02, 0x83, 0x04, 0x85}.
  - in = {464'b0, 0xFF, 0xE7, 0x5D, 0x64}.
- Hold m_ready = 0 for 20 cycles while driving s_valid.
  - Required: s_ready stays 0 and outputs are unchanged.
  - Then pulse m_ready: m_valid drops on the next cycle.
- Count byte 0x00, then bytes up to s_last.
  - Required: err pulses, err_code = 1, bytes are drained, m_valid stays 0.
  - A following good frame loads correctly.
- s_last on the 3rd weight byte of a K=4 frame.
  - Required: err_code = 2 and the state returns to S_BIAS.
  - Next, a K=1 frame missing s_last: err_code = 3, drained until s_last.
- Full-width frame, K=62, all bytes 0x7F.
  - Required: every lane is 0x7F.
  - Following K=1 frame: lanes 1..61 read 0.
- Assert rst during S_INPUT.
  - Required: all outputs are 0 immediately.
  - With LOADER_REUSE_WEIGHTS_EN: a load with K=4, then count 0x84 plus 4 inputs, keeps the prior weights.
